regfile_writeback_unit: RTL and testbench
=========================================

Name: regfile_writeback_unit

Overview:
Writeback stage that feeds the single write port of register_file.
- Accepts two result sources: a single-cycle ALU port with no buffering, and a memory-load response port buffered in a small FIFO.
- Arbitrates between them, drops writes to x0, and drives a registered wr_enable/wr_addr/wr_data triple straight into register_file.

Parameters:
DATA_WIDTH, 32, width of result data
ADDR_WIDTH, 5, register index width
DEPTH, 4, load-response FIFO entries; power of two, >=2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
alu_valid_i  in  1  ALU result valid
alu_ready_o  out  1  ALU result accepted this cycle
alu_rd_i  in  ADDR_WIDTH  ALU destination register
alu_data_i  in  DATA_WIDTH  ALU result
mem_valid_i  in  1  load response valid
mem_ready_o  out  1  load response accepted (FIFO push)
mem_rd_i  in  ADDR_WIDTH  load destination register
mem_data_i  in  DATA_WIDTH  load data
wr_enable_o  out  1  to register_file wr_enable_i
wr_addr_o  out  ADDR_WIDTH  to register_file wr_addr_i
wr_data_o  out  DATA_WIDTH  to register_file wr_data_i
fifo_count_o  out  $clog2(DEPTH+1)  current FIFO occupancy
byp_addr1_i, byp_addr2_i  in  ADDR_WIDTH  read addresses for bypass check
byp_hit1_o, byp_hit2_o  out  1  bypass hit
byp_data1_o, byp_data2_o  out  DATA_WIDTH  bypass data

Behaviour:
- Reset (rst_i high at posedge):
  - FIFO emptied; any contents are discarded, including on reset mid-operation.
  - wr_enable_o=0, wr_addr_o=0, wr_data_o=0, fifo_count_o=0.
  - While rst_i is high, alu_ready_o=0 and mem_ready_o=0 (combinational).
- Handshakes: a beat transfers when valid && ready.
  - Once valid is raised, the source holds valid, rd and data stable until accepted.
- mem_ready_o = !full.
  - No push-through-on-pop: a full FIFO rejects a push even in a cycle where it pops.
- Arbitration each cycle, exactly one winner or none:
  - FIFO full -> FIFO head wins, and alu_ready_o=0.
  - else alu_valid_i -> ALU wins, and alu_ready_o=1.
  - else FIFO non-empty -> FIFO head wins.
  - else idle.
- alu_ready_o = !full && !rst_i; this is independent of alu_valid_i.
- Simultaneous mem push and FIFO pop in one cycle: count is unchanged and order is preserved.
- Latency:
  - ALU beat accepted at edge N -> wr_enable_o high during cycle N+1.
  - Load pushed at edge N -> earliest pop at edge N+1 -> wr_enable_o during cycle N+2.
- Output register: every edge it loads the winner's rd/data; wr_enable_o = winner exists && rd != 0.
  - A winner with rd==0 is consumed (popped/acked), but wr_enable_o=0 and wr_addr_o/wr_data_o hold their previous values.
  - With no winner: wr_enable_o=0 and addr/data hold.
- Ordering: loads retire in arrival order. No ordering is guaranteed between ALU and load results; the issue logic owns WAW hazards.
- FIFO pointers are log2(DEPTH) bits and wrap naturally; full/empty are derived from the count.

Optional Feature:
Macro RF_WB_BYPASS_EN.
- With it: byp_hitK_o = wr_enable_o && (wr_addr_o == byp_addrK_i) && (byp_addrK_i != 0), combinational. byp_dataK_o = wr_data_o on a hit, else 0. This covers register_file's same-cycle write/read hazard, since register_file does not bypass.
- Without it: the ports remain; byp_hit*_o and byp_data*_o are tied to 0, and byp_addr*_i is unused.

Decomposition:
- riscv_pkg gains:
  - wb_entry_t (packed struct {rd: ADDR_WIDTH, data: DATA_WIDTH})
  - WB_FIFO_DEPTH = 4
- Sub-module wb_fifo:
  - synchronous FIFO of wb_entry_t, parameter DEPTH, sync active-high reset.
  - ports: push/pop/full/empty/count/head.
- The top holds the arbitration, output register and bypass logic.

Test Plan:
- ALU only: alu rd=5, data=0xAAAA_AAAA accepted at edge N -> cycle N+1 shows wr_enable_o=1, wr_addr_o=5, wr_data_o=0xAAAA_AAAA; a register_file read of x5 afterwards returns 0xAAAA_AAAA.
- x0 drop: alu rd=0, data=0xDEAD_BEEF -> alu_ready_o=1, wr_enable_o stays 0, register_file x0 reads 0.
- Load ordering: with alu idle, push loads (3,0x1111),(4,0x2222),(6,0x3333) back-to-back -> writes appear at x3, x4, x6 in that order on consecutive cycles; the first write appears 2 cycles after the first push.
- Full/priority:
  - alu_valid_i held high with rd=7; push DEPTH=4 loads -> mem_ready_o=0 and fifo_count_o=4.
  - While full, alu_ready_o=0 and the FIFO head is written.
  - After the first pop, the ALU write to x7 wins and the FIFO drains afterwards.
- Reset mid-operation: FIFO holding 3 entries, assert rst_i for 1 cycle -> fifo_count_o=0, wr_enable_o=0, the 3 entries never appear on wr_*.
- Bypass (RF_WB_BYPASS_EN defined): wr_enable_o=1, wr_addr_o=15, wr_data_o=0x1234_5678; byp_addr1_i=15, byp_addr2_i=0 -> byp_hit1_o=1, byp_data1_o=0x1234_5678, byp_hit2_o=0. With the macro undefined, all bypass outputs are 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types for the writeback path: result entry layout, FIFO depth
// and the arbitration source encoding.
package riscv_pkg;

    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned WB_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] rd;
        logic [RF_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_FIFO = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries with a sync active-high reset.
// Pointers wrap naturally (DEPTH is a power of two); full/empty come from the count.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH,
    parameter type         T     = wb_entry_t
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  T                             i_push_data,
    input  logic                         i_pop,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output T                             o_head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    T                r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // A full FIFO refuses the push even when it pops in the same cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/regfile_writeback_unit.sv
// Writeback stage: arbitrates ALU results against buffered load responses and
// drives a registered write into register_file. Optional bypass: RF_WB_BYPASS_EN.
module regfile_writeback_unit
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = WB_FIFO_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          alu_valid_i,
    output logic                          alu_ready_o,
    input  logic [ADDR_WIDTH-1:0]         alu_rd_i,
    input  logic [DATA_WIDTH-1:0]         alu_data_i,
    input  logic                          mem_valid_i,
    output logic                          mem_ready_o,
    input  logic [ADDR_WIDTH-1:0]         mem_rd_i,
    input  logic [DATA_WIDTH-1:0]         mem_data_i,
    output logic                          wr_enable_o,
    output logic [ADDR_WIDTH-1:0]         wr_addr_o,
    output logic [DATA_WIDTH-1:0]         wr_data_o,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_count_o,
    input  logic [ADDR_WIDTH-1:0]         byp_addr1_i,
    input  logic [ADDR_WIDTH-1:0]         byp_addr2_i,
    output logic                          byp_hit1_o,
    output logic                          byp_hit2_o,
    output logic [DATA_WIDTH-1:0]         byp_data1_o,
    output logic [DATA_WIDTH-1:0]         byp_data2_o
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic                         w_full;
    logic                         w_empty;
    logic                         w_push;
    logic                         w_pop;
    logic [$clog2(DEPTH+1)-1:0]   w_count;
    entry_t                       w_head;
    entry_t                       w_push_data;
    wb_src_e                      w_src;
    logic [ADDR_WIDTH-1:0]        w_win_rd;
    logic [DATA_WIDTH-1:0]        w_win_data;

    logic                         r_wr_enable;
    logic [ADDR_WIDTH-1:0]        r_wr_addr;
    logic [DATA_WIDTH-1:0]        r_wr_data;

    assign alu_ready_o  = !w_full && !rst_i;
    assign mem_ready_o  = !w_full && !rst_i;
    assign w_push       = mem_valid_i && mem_ready_o;
    assign w_push_data  = '{rd: mem_rd_i, data: mem_data_i};
    assign fifo_count_o = w_count;

    wb_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    // A full FIFO outranks the ALU so the load path can never deadlock.
    always_comb begin
        w_src = WB_SRC_NONE;
        if (!rst_i) begin
            if (w_full) begin
                w_src = WB_SRC_FIFO;
            end else if (alu_valid_i) begin
                w_src = WB_SRC_ALU;
            end else if (!w_empty) begin
                w_src = WB_SRC_FIFO;
            end
        end
    end

    assign w_pop = (w_src == WB_SRC_FIFO);

    always_comb begin
        w_win_rd   = '0;
        w_win_data = '0;
        case (w_src)
            WB_SRC_ALU: begin
                w_win_rd   = alu_rd_i;
                w_win_data = alu_data_i;
            end
            WB_SRC_FIFO: begin
                w_win_rd   = w_head.rd;
                w_win_data = w_head.data;
            end
            default: begin
                w_win_rd   = '0;
                w_win_data = '0;
            end
        endcase
    end

    // x0 winners are consumed but leave addr/data holding their last value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_enable <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else if ((w_src != WB_SRC_NONE) && (w_win_rd != '0)) begin
            r_wr_enable <= 1'b1;
            r_wr_addr   <= w_win_rd;
            r_wr_data   <= w_win_data;
        end else begin
            r_wr_enable <= 1'b0;
        end
    end

    assign wr_enable_o = r_wr_enable;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;

`ifdef RF_WB_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    assign w_hit1      = r_wr_enable && (r_wr_addr == byp_addr1_i) && (byp_addr1_i != '0);
    assign w_hit2      = r_wr_enable && (r_wr_addr == byp_addr2_i) && (byp_addr2_i != '0);
    assign byp_hit1_o  = w_hit1;
    assign byp_hit2_o  = w_hit2;
    assign byp_data1_o = w_hit1 ? r_wr_data : '0;
    assign byp_data2_o = w_hit2 ? r_wr_data : '0;
`else
    logic w_byp_unused;

    assign w_byp_unused = ^{byp_addr1_i, byp_addr2_i};
    assign byp_hit1_o   = 1'b0;
    assign byp_hit2_o   = 1'b0;
    assign byp_data1_o  = '0;
    assign byp_data2_o  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Self-checking bench for regfile_writeback_unit: directed scenarios followed by
// random traffic, all checked against a queue-based model of the writeback rules.
module tb_regfile_writeback_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned DEPTH = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            alu_valid_i;
    logic            alu_ready_o;
    logic [AW-1:0]   alu_rd_i;
    logic [DW-1:0]   alu_data_i;
    logic            mem_valid_i;
    logic            mem_ready_o;
    logic [AW-1:0]   mem_rd_i;
    logic [DW-1:0]   mem_data_i;
    logic            wr_enable_o;
    logic [AW-1:0]   wr_addr_o;
    logic [DW-1:0]   wr_data_o;
    logic [2:0]      fifo_count_o;
    logic [AW-1:0]   byp_addr1_i;
    logic [AW-1:0]   byp_addr2_i;
    logic            byp_hit1_o;
    logic            byp_hit2_o;
    logic [DW-1:0]   byp_data1_o;
    logic [DW-1:0]   byp_data2_o;

    regfile_writeback_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alu_valid_i  (alu_valid_i),
        .alu_ready_o  (alu_ready_o),
        .alu_rd_i     (alu_rd_i),
        .alu_data_i   (alu_data_i),
        .mem_valid_i  (mem_valid_i),
        .mem_ready_o  (mem_ready_o),
        .mem_rd_i     (mem_rd_i),
        .mem_data_i   (mem_data_i),
        .wr_enable_o  (wr_enable_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .fifo_count_o (fifo_count_o),
        .byp_addr1_i  (byp_addr1_i),
        .byp_addr2_i  (byp_addr2_i),
        .byp_hit1_o   (byp_hit1_o),
        .byp_hit2_o   (byp_hit2_o),
        .byp_data1_o  (byp_data1_o),
        .byp_data2_o  (byp_data2_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Stimulus requested for the next cycle.
    logic            d_rst;
    logic            d_av;
    logic [AW-1:0]   d_ard;
    logic [DW-1:0]   d_adata;
    logic            d_mv;
    logic [AW-1:0]   d_mrd;
    logic [DW-1:0]   d_mdata;

    // Reference model state: pending loads in arrival order and expected outputs.
    logic [AW+DW-1:0] q[$];
    logic             e_en;
    logic [AW-1:0]    e_addr;
    logic [DW-1:0]    e_data;
    logic             alu_acc;
    logic             mem_acc;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [AW+DW-1:0] w;
        logic             have;
        logic             full;
        logic             h1;
        logic             h2;

        rst_i       = d_rst;
        alu_valid_i = d_av;
        alu_rd_i    = d_ard;
        alu_data_i  = d_adata;
        mem_valid_i = d_mv;
        mem_rd_i    = d_mrd;
        mem_data_i  = d_mdata;
        #1;
        full = (q.size() == DEPTH);
        chk("alu_ready", {63'b0, alu_ready_o}, {63'b0, (!d_rst && !full)});
        chk("mem_ready", {63'b0, mem_ready_o}, {63'b0, (!d_rst && !full)});

        if (d_rst) begin
            q.delete();
            e_en    = 1'b0;
            e_addr  = '0;
            e_data  = '0;
            alu_acc = 1'b0;
            mem_acc = 1'b0;
        end else begin
            have    = 1'b0;
            alu_acc = 1'b0;
            w       = '0;
            if (full) begin
                w = q.pop_front();
                have = 1'b1;
            end else if (d_av) begin
                w = {d_ard, d_adata};
                have = 1'b1;
                alu_acc = 1'b1;
            end else if (q.size() > 0) begin
                w = q.pop_front();
                have = 1'b1;
            end
            mem_acc = d_mv && !full;
            if (mem_acc) q.push_back({d_mrd, d_mdata});
            if (have && (w[AW+DW-1:DW] != '0)) begin
                e_en   = 1'b1;
                e_addr = w[AW+DW-1:DW];
                e_data = w[DW-1:0];
            end else begin
                e_en = 1'b0;
            end
        end

        @(negedge clk_i);
        chk("wr_enable", {63'b0, wr_enable_o}, {63'b0, e_en});
        chk("wr_addr", {59'b0, wr_addr_o}, {59'b0, e_addr});
        chk("wr_data", {32'b0, wr_data_o}, {32'b0, e_data});
        chk("fifo_count", {61'b0, fifo_count_o}, 64'(q.size()));

        byp_addr1_i = ($urandom_range(0, 1) == 0) ? e_addr : AW'($urandom);
        byp_addr2_i = ($urandom_range(0, 3) == 0) ? 5'd0 : (($urandom_range(0, 1) == 0) ? e_addr : AW'($urandom));
        #1;
`ifdef RF_WB_BYPASS_EN
        h1 = e_en && (byp_addr1_i == e_addr) && (byp_addr1_i != '0);
        h2 = e_en && (byp_addr2_i == e_addr) && (byp_addr2_i != '0);
        chk("byp_hit1", {63'b0, byp_hit1_o}, {63'b0, h1});
        chk("byp_hit2", {63'b0, byp_hit2_o}, {63'b0, h2});
        chk("byp_data1", {32'b0, byp_data1_o}, {32'b0, (h1 ? e_data : 32'h0)});
        chk("byp_data2", {32'b0, byp_data2_o}, {32'b0, (h2 ? e_data : 32'h0)});
`else
        h1 = 1'b0;
        h2 = 1'b0;
        chk("byp_hit1", {63'b0, byp_hit1_o}, {63'b0, h1});
        chk("byp_hit2", {63'b0, byp_hit2_o}, {63'b0, h2});
        chk("byp_data1", {32'b0, byp_data1_o}, 64'h0);
        chk("byp_data2", {32'b0, byp_data2_o}, 64'h0);
`endif
    endtask

    initial begin
        int unsigned ld;

        q.delete();
        e_en = 1'b0; e_addr = '0; e_data = '0;
        alu_acc = 1'b0; mem_acc = 1'b0;
        d_rst = 1'b1; d_av = 1'b0; d_ard = '0; d_adata = '0;
        d_mv = 1'b0; d_mrd = '0; d_mdata = '0;
        byp_addr1_i = '0; byp_addr2_i = '0;

        repeat (2) cycle();
        d_rst = 1'b0;

        // ALU only, then a write to x0
        d_av = 1'b1; d_ard = 5'd5; d_adata = 32'hAAAA_AAAA; cycle();
        d_av = 1'b0; cycle();
        d_av = 1'b1; d_ard = 5'd0; d_adata = 32'hDEAD_BEEF; cycle();
        d_av = 1'b0; repeat (2) cycle();

        // Back-to-back loads with the ALU idle
        d_mv = 1'b1;
        d_mrd = 5'd3; d_mdata = 32'h1111; cycle();
        d_mrd = 5'd4; d_mdata = 32'h2222; cycle();
        d_mrd = 5'd6; d_mdata = 32'h3333; cycle();
        d_mv = 1'b0; repeat (4) cycle();

        // ALU held busy while loads fill the FIFO
        d_av = 1'b1; d_ard = 5'd7; d_adata = 32'h7777_7777;
        ld = 0;
        d_mv = 1'b1; d_mrd = 5'd8; d_mdata = 32'h8000_0000;
        repeat (10) begin
            cycle();
            if (mem_acc) begin
                ld++;
                d_mrd = AW'(8 + ld);
                d_mdata = 32'h8000_0000 + ld;
            end
        end
        d_mv = 1'b0;
        repeat (3) cycle();
        d_av = 1'b0;
        repeat (6) cycle();

        // Reset with three loads still buffered
        d_av = 1'b1; d_ard = 5'd9; d_adata = 32'h9999_9999;
        d_mv = 1'b1;
        d_mrd = 5'd20; d_mdata = 32'h2020; cycle();
        d_mrd = 5'd21; d_mdata = 32'h2121; cycle();
        d_mrd = 5'd22; d_mdata = 32'h2222; cycle();
        d_mv = 1'b0;
        d_rst = 1'b1; cycle();
        d_rst = 1'b0; d_av = 1'b0;
        repeat (5) cycle();

        // Random traffic honouring the hold-until-accepted rule
        for (int i = 0; i < 3000; i++) begin
            d_rst = ($urandom_range(0, 59) == 0);
            if (!d_av || alu_acc) begin
                d_av    = ($urandom_range(0, 99) < 45);
                d_ard   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
                d_adata = $urandom;
            end
            if (!d_mv || mem_acc) begin
                d_mv    = ($urandom_range(0, 99) < 55);
                d_mrd   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
                d_mdata = $urandom;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
